seq_digit_streamer: RTL and testbench

Transmit side of the digit-serial MAC datapath. Accepts one job per handshake: K unsigned P-bit row operands, K column operands and a 32-bit accumulator seed. It emits the rows as a stream of D-bit digits, LSB digit first, with the columns and seed held stable. Every beat carries first/last framing and a shift amount, so a downstream seq_mult_adder-style accumulator can load the seed on `first_o` and add `digit_product << shift_o` on every beat.

---
 rtl/seq_digit_streamer_if.sv | 28 ++
 rtl/seq_digit_streamer.sv | 67 ++++++
 tb/tb_seq_digit_streamer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_digit_streamer_if.sv
// seq_digit_streamer_if: job-in / digit-beat-out handshake bundle for seq_digit_streamer
interface seq_digit_streamer_if #(
  parameter int K = 2,
  parameter int P = 8,
  parameter int D = 2
);
  logic [K-1:0][P-1:0] row_i;
  logic [K-1:0][P-1:0] column_i;
  logic [31:0]         c_in_i;
  logic                valid_i;
  logic                ready_o;
  logic [K-1:0][D-1:0] a_digit_o;
  logic [K-1:0][P-1:0] b_o;
  logic [31:0]         c_o;
  logic [4:0]          shift_o;
  logic                first_o;
  logic                last_o;
  logic                valid_o;
  logic                ready_i;
  modport master (
    output row_i, column_i, c_in_i, valid_i, ready_i,
    input  ready_o, a_digit_o, b_o, c_o, shift_o, first_o, last_o, valid_o
  );
  modport slave (
    input  row_i, column_i, c_in_i, valid_i, ready_i,
    output ready_o, a_digit_o, b_o, c_o, shift_o, first_o, last_o, valid_o
  );
endinterface

// File: rtl/seq_digit_streamer.sv
// seq_digit_streamer: streams K row operands as D-bit digits (LSB first) with framing and shift; SEQ_STREAM_SKIP_ZERO_EN ends a job on its highest non-zero digit
module seq_digit_streamer #(
  parameter int K = 2,
  parameter int P = 8,
  parameter int D = 2
) (
  input logic clk_i,
  input logic rst_i,
  seq_digit_streamer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [4:0] LAST_SH = 5'(P - D);
  logic [0:0]          state;
  logic [4:0]          shift;
  logic [K-1:0][P-1:0] row_reg;
  logic [K-1:0][P-1:0] b_reg;
  logic [31:0]         c_reg;
  logic                stream;
  logic                at_last;
  logic                take;
  logic                advance;
  assign stream = state == STREAM;
`ifdef SEQ_STREAM_SKIP_ZERO_EN
  logic upper_zero;
  // the job may end once no lane holds a set bit above the current digit
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < K; k++) upper_zero = upper_zero && ((row_reg[k] >> D) == '0);
  end
  assign at_last = (shift == LAST_SH) || upper_zero;
`else
  assign at_last = shift == LAST_SH;
`endif
  assign bus.valid_o = stream;
  assign bus.first_o = stream && (shift == '0);
  assign bus.last_o  = stream && at_last;
  assign bus.shift_o = shift;
  assign bus.b_o     = b_reg;
  assign bus.c_o     = c_reg;
  assign bus.ready_o = !stream || (at_last && bus.ready_i);
  assign take        = bus.valid_i && bus.ready_o;
  assign advance     = stream && bus.ready_i;
  for (genvar k = 0; k < K; k++) begin : g_lane
    assign bus.a_digit_o[k] = row_reg[k][D-1:0];
  end
  // job capture has priority so a new job chains straight onto the last beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shift   <= '0;
      row_reg <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
    end else if (take) begin
      state   <= STREAM;
      shift   <= '0;
      row_reg <= bus.row_i;
      b_reg   <= bus.column_i;
      c_reg   <= bus.c_in_i;
    end else if (advance) begin
      state <= at_last ? IDLE : STREAM;
      shift <= at_last ? '0 : shift + 5'(D);
      for (int k = 0; k < K; k++) row_reg[k] <= row_reg[k] >> D;
    end
  end
endmodule

// File: tb/tb_seq_digit_streamer.sv
// tb_seq_digit_streamer: directed self-checking bench for seq_digit_streamer (K=2, P=8, D=2)
module tb_seq_digit_streamer;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  int fails = 0;
  int nz;
`ifdef SEQ_STREAM_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic [1:0] a_l0 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [1:0] a_l1 [4] = '{2'd1, 2'd0, 2'd0, 2'd0};
  logic [1:0] b_l0 [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  logic [1:0] b_l1 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] z_l0 [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
  seq_digit_streamer_if #(.K(2), .P(8), .D(2)) bus ();
  seq_digit_streamer #(.K(2), .P(8), .D(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  task automatic beat(input string t, input logic [1:0] a0, input logic [1:0] a1, input int sh,
                      input logic f, input logic l, input logic r, input logic [31:0] c);
    chk({t, ".valid"}, 32'(bus.valid_o), 1);
    chk({t, ".a0"}, 32'(bus.a_digit_o[0]), 32'(a0));
    chk({t, ".a1"}, 32'(bus.a_digit_o[1]), 32'(a1));
    chk({t, ".shift"}, 32'(bus.shift_o), 32'(sh));
    chk({t, ".first"}, 32'(bus.first_o), 32'(f));
    chk({t, ".last"}, 32'(bus.last_o), 32'(l));
    chk({t, ".ready_o"}, 32'(bus.ready_o), 32'(r));
    chk({t, ".c"}, bus.c_o, c);
  endtask
  task automatic load(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] c0,
                      input logic [7:0] c1, input logic [31:0] cin);
    bus.row_i[0] = r0;
    bus.row_i[1] = r1;
    bus.column_i[0] = c0;
    bus.column_i[1] = c1;
    bus.c_in_i = cin;
    bus.valid_i = 1'b1;
  endtask
  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.row_i = '0;
    bus.column_i = '0;
    bus.c_in_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.valid", 32'(bus.valid_o), 0);
    chk("rst.first", 32'(bus.first_o), 0);
    chk("rst.last", 32'(bus.last_o), 0);
    chk("rst.shift", 32'(bus.shift_o), 0);
    chk("rst.a", 32'(bus.a_digit_o), 0);
    chk("rst.b", 32'(bus.b_o), 0);
    chk("rst.c", bus.c_o, 0);
    chk("rst.ready_o", 32'(bus.ready_o), 1);
    @(negedge clk);
    load(8'hB4, 8'h01, 8'h34, 8'h12, 32'd7);
    #1;
    chk("single.accept", 32'(bus.ready_o), 1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      beat($sformatf("single%0d", b), a_l0[b], a_l1[b], 2 * b, b == 0, b == 3, b == 3, 32'd7);
      chk($sformatf("single%0d.b", b), 32'(bus.b_o), 32'h1234);
    end
    @(negedge clk);
    #1;
    chk("single.idle_valid", 32'(bus.valid_o), 0);
    chk("single.idle_ready", 32'(bus.ready_o), 1);
    load(8'hB4, 8'h01, 8'h00, 8'h00, 32'd3);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    beat("bp0", 2'd0, 2'd1, 0, 1'b1, 1'b0, 1'b0, 32'd3);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      bus.ready_i = 1'b0;
      #1;
      beat($sformatf("bp_hold%0d", h), 2'd1, 2'd0, 2, 1'b0, 1'b0, 1'b0, 32'd3);
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    #1;
    beat("bp_release", 2'd1, 2'd0, 2, 1'b0, 1'b0, 1'b0, 32'd3);
    @(negedge clk);
    #1;
    beat("bp2", 2'd3, 2'd0, 4, 1'b0, 1'b0, 1'b0, 32'd3);
    @(negedge clk);
    #1;
    beat("bp3", 2'd2, 2'd0, 6, 1'b0, 1'b1, 1'b1, 32'd3);
    @(negedge clk);
    #1;
    chk("bp.idle_valid", 32'(bus.valid_o), 0);
    load(8'hB4, 8'h01, 8'h34, 8'h12, 32'd5);
    #1;
    chk("b2b.accept", 32'(bus.ready_o), 1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 0) load(8'h1B, 8'hE4, 8'h56, 8'h78, 32'd9);
      #1;
      beat($sformatf("b2b_a%0d", b), a_l0[b], a_l1[b], 2 * b, b == 0, b == 3, b == 3, 32'd5);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      beat($sformatf("b2b_b%0d", b), b_l0[b], b_l1[b], 2 * b, b == 0, b == 3, b == 3, 32'd9);
      chk($sformatf("b2b_b%0d.b", b), 32'(bus.b_o), 32'h7856);
    end
    @(negedge clk);
    #1;
    chk("b2b.idle_valid", 32'(bus.valid_o), 0);
    load(8'hB4, 8'h01, 8'h34, 8'h12, 32'd7);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      beat($sformatf("rs%0d", b), a_l0[b], a_l1[b], 2 * b, b == 0, 1'b0, 1'b0, 32'd7);
    end
    rst = 1'b1;
    #1;
    chk("rs.valid", 32'(bus.valid_o), 0);
    chk("rs.first", 32'(bus.first_o), 0);
    chk("rs.last", 32'(bus.last_o), 0);
    chk("rs.shift", 32'(bus.shift_o), 0);
    chk("rs.a", 32'(bus.a_digit_o), 0);
    chk("rs.b", 32'(bus.b_o), 0);
    chk("rs.c", bus.c_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs.ready_o", 32'(bus.ready_o), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rs.quiet%0d", i), 32'(bus.valid_o), 0);
    end
    nz = SKIP ? 2 : 4;
    load(8'h05, 8'h00, 8'h01, 8'h02, 32'd1);
    for (int b = 0; b < nz; b++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      beat($sformatf("sz%0d", b), z_l0[b], 2'd0, 2 * b, b == 0, b == nz - 1, b == nz - 1, 32'd1);
    end
    @(negedge clk);
    #1;
    chk("sz.idle_valid", 32'(bus.valid_o), 0);
    nz = SKIP ? 1 : 4;
    load(8'h00, 8'h00, 8'h01, 8'h02, 32'd2);
    for (int b = 0; b < nz; b++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      beat($sformatf("zr%0d", b), 2'd0, 2'd0, 2 * b, b == 0, b == nz - 1, b == nz - 1, 32'd2);
    end
    @(negedge clk);
    #1;
    chk("zr.idle_valid", 32'(bus.valid_o), 0);
    chk("zr.idle_ready", 32'(bus.ready_o), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
